sramlike_arbiter_nx1: RTL and testbench

//  Parametrised N-to-1 merger for the SRAM-like bus (req/wr/size/addr/wdata/rdata/addr_ok/data_ok).
//  It generalises the fixed two-way data-path merge to NUM_MASTERS requesters.

---
 rtl/sramlike_arbiter_nx1.sv | 123 ++++++++++++
 tb/tb_sramlike_arbiter_nx1.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sramlike_arbiter_nx1.sv
// Round-robin N-to-1 merger for the SRAM-like bus with an in-order ID FIFO
// that routes each downstream response back to the master that issued it.
module sramlike_arbiter_nx1 #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_wr,
  input  logic [NUM_MASTERS*2-1:0]      m_size,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_addr_ok,
  output logic [NUM_MASTERS-1:0]        m_data_ok,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_wr,
  output logic [1:0]                    s_size,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_addr_ok,
  input  logic                          s_data_ok,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          protocol_err
);

  localparam int unsigned NM  = NUM_MASTERS;
  localparam int unsigned IDW = $clog2(NUM_MASTERS);
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [IDW-1:0] fifo [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [IDW-1:0] rr_ptr, lock_id, gnt, head;
  logic           lock_valid, gnt_valid, req_g, full, accept;
  logic           has_out, pop, bypass, push, spurious;

  always_comb begin
    int unsigned idx;
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    if (lock_valid) begin
      gnt       = lock_id;
      gnt_valid = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NM; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NM) idx = idx - NM;
        if (!gnt_valid && m_req[IDW'(idx)]) begin
          gnt       = IDW'(idx);
          gnt_valid = 1'b1;
        end
      end
    end
  end

  assign req_g    = gnt_valid & m_req[gnt];
  assign full     = (count == CW'(MAX_OUTSTANDING));
  assign s_req    = req_g & ~full;
  assign accept   = s_req & s_addr_ok;
  assign has_out  = (count != '0);
  assign head     = fifo[rd_ptr];
  assign pop      = s_data_ok & has_out;
  // With nothing outstanding, a response in the accepting cycle belongs to that request.
  assign bypass   = s_data_ok & ~has_out & accept;
  assign push     = accept & ~bypass;
  assign spurious = s_data_ok & ~has_out & ~accept;
  assign m_rdata  = s_rdata;

  always_comb begin
    s_wr      = 1'b0;
    s_size    = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (req_g && gnt == IDW'(i)) begin
        s_wr    = m_wr[i];
        s_size  = m_size[i*2 +: 2];
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
      m_addr_ok[i] = accept && gnt == IDW'(i);
      m_data_ok[i] = (pop && head == IDW'(i)) || (bypass && gnt == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < MAX_OUTSTANDING; j++) fifo[j] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rr_ptr       <= '0;
      lock_valid   <= 1'b0;
      lock_id      <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= gnt;
        wr_ptr       <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (accept) begin
        rr_ptr     <= (gnt == IDW'(NUM_MASTERS - 1)) ? '0 : gnt + 1'b1;
        lock_valid <= 1'b0;
      end else if (s_req) begin
        lock_valid <= 1'b1;
        lock_id    <= gnt;
      end
      if (spurious) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sramlike_arbiter_nx1.sv
// Scenario bench for the two-master arbiter: grants, locking, FIFO full,
// bypass response, spurious response and mid-flight reset.
module tb_sramlike_arbiter_nx1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_wr;
  logic [3:0]  m_size;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok = 1'b0;
  logic        s_data_ok = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        protocol_err;

  int total = 0;
  int bad   = 0;
  int unsigned exp_q[$];

  logic [31:0] addr_v  [2] = '{32'h1000_0000, 32'h2000_0040};
  logic [31:0] wdata_v [2] = '{32'hAAAA_0000, 32'h5555_1111};
  logic        wr_v    [2] = '{1'b0, 1'b1};
  logic [1:0]  size_v  [2] = '{2'd2, 2'd1};

  sramlike_arbiter_nx1 #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    m_wr    = {wr_v[1], wr_v[0]};
    m_size  = {size_v[1], size_v[0]};
    m_addr  = {addr_v[1], addr_v[0]};
    m_wdata = {wdata_v[1], wdata_v[0]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; outputs are read 1 ns later.
  task automatic drive(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    m_req = req; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (m_addr_ok !== 2'b00 || m_data_ok !== 2'b00) begin bad++; $display("FAIL reset_m_ok: got %b/%b want 00/00", m_addr_ok, m_data_ok); end
    total++; if ({s_req, s_wr, s_size, s_addr, s_wdata} !== '0) begin bad++; $display("FAIL reset_s_fields: got req=%b addr=%h want all zero", s_req, s_addr); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", protocol_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int unsigned id, e;
    do_reset();
    for (int unsigned k = 0; k < 6; k++) begin
      drive(2'b11, 1'b1, k > 0, 32'hC0DE_0000 + k);
      e = k % 2;
      total++; if (m_addr_ok !== 2'(1 << e)) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, m_addr_ok, 2'(1 << e)); end
      total++; if (s_addr !== addr_v[e] || s_wr !== wr_v[e] || s_size !== size_v[e] || s_wdata !== wdata_v[e]) begin bad++; $display("FAIL rr_fields[%0d]: got addr=%h want %h", k, s_addr, addr_v[e]); end
      if (k > 0) begin
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL rr_sb_empty[%0d]: got empty queue want entry", k); end
        else begin
          id = exp_q.pop_front();
          total++; if (m_data_ok !== 2'(1 << id)) begin bad++; $display("FAIL rr_data_ok[%0d]: got %b want %b", k, m_data_ok, 2'(1 << id)); end
          total++; if (m_rdata !== 32'hC0DE_0000 + k) begin bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, m_rdata, 32'hC0DE_0000 + k); end
        end
      end
      exp_q.push_back(e);
    end
    drive(2'b00, 1'b0, 1'b1, 32'h0);
    id = exp_q.pop_front();
    total++; if (m_data_ok !== 2'(1 << id)) begin bad++; $display("FAIL rr_last_data_ok: got %b want %b", m_data_ok, 2'(1 << id)); end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_lock();
    int unsigned id;
    do_reset();
    drive(2'b01, 1'b1, 1'b1, 32'h1);
    total++; if (m_data_ok !== 2'b01) begin bad++; $display("FAIL lock_pre_bypass: got %b want 01", m_data_ok); end
    for (int unsigned k = 0; k < 3; k++) begin
      drive(2'b01, 1'b0, 1'b0, 32'h0);
      total++; if (s_req !== 1'b1 || m_addr_ok !== 2'b00 || s_addr !== addr_v[0]) begin bad++; $display("FAIL lock_wait[%0d]: got req=%b ok=%b addr=%h want 1/00/%h", k, s_req, m_addr_ok, s_addr, addr_v[0]); end
    end
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    total++; if (s_addr !== addr_v[0]) begin bad++; $display("FAIL lock_hold: got addr=%h want %h", s_addr, addr_v[0]); end
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    total++; if (m_addr_ok !== 2'b01) begin bad++; $display("FAIL lock_accept0: got %b want 01", m_addr_ok); end
    exp_q.push_back(0);
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    total++; if (m_addr_ok !== 2'b10) begin bad++; $display("FAIL lock_accept1: got %b want 10", m_addr_ok); end
    exp_q.push_back(1);
    for (int unsigned k = 0; k < 2; k++) begin
      drive(2'b00, 1'b0, 1'b1, 32'h0);
      id = exp_q.pop_front();
      total++; if (m_data_ok !== 2'(1 << id)) begin bad++; $display("FAIL lock_drain[%0d]: got %b want %b", k, m_data_ok, 2'(1 << id)); end
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic fill_and_check(input logic [1:0] req, input int unsigned m, input string tag);
    for (int unsigned k = 0; k < 4; k++) begin
      drive(req, 1'b1, 1'b0, 32'h0);
      total++; if (m_addr_ok !== 2'(1 << m)) begin bad++; $display("FAIL %s_fill[%0d]: got %b want %b", tag, k, m_addr_ok, 2'(1 << m)); end
      exp_q.push_back(m);
    end
    drive(req, 1'b1, 1'b0, 32'h0);
    total++; if (s_req !== 1'b0 || m_addr_ok !== 2'b00) begin bad++; $display("FAIL %s_full: got req=%b ok=%b want 0/00", tag, s_req, m_addr_ok); end
  endtask

  task automatic drain(input string tag);
    int unsigned id;
    while (exp_q.size() > 0) begin
      drive(2'b00, 1'b0, 1'b1, 32'h0);
      id = exp_q.pop_front();
      total++; if (m_data_ok !== 2'(1 << id)) begin bad++; $display("FAIL %s_drain: got %b want %b", tag, m_data_ok, 2'(1 << id)); end
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_full();
    int unsigned id;
    do_reset();
    fill_and_check(2'b01, 0, "full");
    drive(2'b01, 1'b1, 1'b1, 32'h0);
    id = exp_q.pop_front();
    total++; if (s_req !== 1'b0 || m_addr_ok !== 2'b00) begin bad++; $display("FAIL full_pop_same: got req=%b ok=%b want 0/00", s_req, m_addr_ok); end
    total++; if (m_data_ok !== 2'(1 << id)) begin bad++; $display("FAIL full_pop_data: got %b want %b", m_data_ok, 2'(1 << id)); end
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    total++; if (s_req !== 1'b1 || m_addr_ok !== 2'b01) begin bad++; $display("FAIL full_resume: got req=%b ok=%b want 1/01", s_req, m_addr_ok); end
    exp_q.push_back(0);
    drain("full");
  endtask

  task automatic test_bypass();
    do_reset();
    drive(2'b10, 1'b1, 1'b1, 32'hDEAD_BEEF);
    total++; if (m_addr_ok !== 2'b10 || m_data_ok !== 2'b10) begin bad++; $display("FAIL bypass_ok: got %b/%b want 10/10", m_addr_ok, m_data_ok); end
    total++; if (m_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_rdata: got %h want deadbeef", m_rdata); end
    fill_and_check(2'b10, 1, "bypass");
    drain("bypass");
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL bypass_perr: got %b want 0", protocol_err); end
  endtask

  task automatic test_spurious();
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 32'h1234_5678);
    total++; if (m_data_ok !== 2'b00) begin bad++; $display("FAIL spur_data_ok: got %b want 00", m_data_ok); end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL spur_perr: got %b want 1", protocol_err); end
    for (int unsigned k = 0; k < 3; k++) drive(2'b00, 1'b0, 1'b0, 32'h0);
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL spur_sticky: got %b want 1", protocol_err); end
  endtask

  // Runs straight after test_spurious so protocol_err is set when rst hits.
  task automatic test_reset_midflight();
    for (int unsigned k = 0; k < 3; k++) begin
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      total++; if (m_addr_ok !== 2'(1 << (k % 2))) begin bad++; $display("FAIL mid_accept[%0d]: got %b want %b", k, m_addr_ok, 2'(1 << (k % 2))); end
    end
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b1; m_req = '0;
    #1;
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL mid_perr_clear: got %b want 0", protocol_err); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    total++; if (s_req !== 1'b1 || s_addr !== addr_v[0]) begin bad++; $display("FAIL mid_rr_lock_clear: got req=%b addr=%h want 1/%h", s_req, s_addr, addr_v[0]); end
    drive(2'b00, 1'b0, 1'b1, 32'h0);
    total++; if (m_data_ok !== 2'b00) begin bad++; $display("FAIL mid_count_clear: got %b want 00", m_data_ok); end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL mid_perr_flag: got %b want 1", protocol_err); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_bypass();
    test_spurious();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
